// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // REM/REMU return the remainder half of the divide result
    function automatic logic is_rem(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Datapath for one bit per cycle shift-add multiply / restoring divide on
// unsigned magnitudes. hi:lo is the 2*W accumulator; for divide hi holds the
// partial remainder and lo the dividend shifting into the quotient.
module muldiv_iter_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_div,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_next_hi,
    output logic [DATA_WIDTH-1:0] o_next_lo
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_b;
    logic             r_div;
    logic [CNT_W-1:0] r_cnt;

    logic [W:0]       w_sum;
    logic [W:0]       w_rem_sh;
    logic             w_ge;
    logic [W-1:0]     w_sub;
    logic [W-1:0]     w_nhi;
    logic [W-1:0]     w_nlo;

    // The step currently in CALC is the last one when the counter reaches W-1
    assign o_last    = (r_cnt == CNT_W'(W - 1));
    assign o_next_hi = w_nhi;
    assign o_next_lo = w_nlo;

    // One iteration: conditional add then shift right (multiply), or shift
    // left then trial subtract (divide). The shifted remainder is always
    // below 2*divisor, so the low W bits of the subtraction are exact.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rem_sh = {r_hi, r_lo[W-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_b});
        w_sub    = w_rem_sh[W-1:0] - r_b;
        w_nhi    = w_sum[W:1];
        w_nlo    = {w_sum[0], r_lo[W-1:1]};
        if (r_div) begin
            w_nhi = w_ge ? w_sub : w_rem_sh[W-1:0];
            w_nlo = {r_lo[W-2:0], w_ge};
        end
    end

    // Accumulator, operand and iteration counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Handles handshake, FSM, operand sign
// conditioning, divide special cases and final result negation; the
// iteration itself lives in muldiv_iter_core.
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int DATA_WIDTH          = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     op,
    input  logic [DATA_WIDTH-1:0]          rs1_val,
    input  logic [DATA_WIDTH-1:0]          rs2_val,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr,
    input  logic                           flush,
    output logic                           busy,
    output logic                           out_valid,
    output logic [REG_FILE_ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]          out_result
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    muldiv_state_e                r_state;
    muldiv_op_e                   r_op;
    logic                         r_neg;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_rd;
    logic [W-1:0]                 r_result;

    muldiv_op_e   w_op;
    logic         w_accept;
    logic         w_rs1_signed;
    logic         w_rs2_signed;
    logic         w_a_neg;
    logic         w_b_neg;
    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;
    logic         w_res_neg;
    logic         w_div0;
    logic         w_ovf;
    logic         w_fast;
    logic [W-1:0] w_fast_res;
    logic         w_last;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;
    logic [2*W-1:0] w_prod_s;
    logic [W-1:0] w_quo_s;
    logic [W-1:0] w_rem_s;
    logic [W-1:0] w_final;

    assign w_op     = muldiv_op_e'(op);
    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid && in_ready;

    assign out_valid  = (r_state == DONE) && !flush;
    assign out_rd     = r_rd;
    assign out_result = r_result;

    // Operand signedness per funct3; MULHSU treats rs2 as unsigned
    always_comb begin
        w_rs1_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                       (w_op == OP_DIV) || (w_op == OP_REM);
        w_rs2_signed = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                       (w_op == OP_DIV) || (w_op == OP_REM);
        w_a_neg   = w_rs1_signed && rs1_val[W-1];
        w_b_neg   = w_rs2_signed && rs2_val[W-1];
        w_a_mag   = w_a_neg ? -rs1_val : rs1_val;
        w_b_mag   = w_b_neg ? -rs2_val : rs2_val;
        w_res_neg = is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
    end

    // Divide-by-zero and signed overflow resolve at accept without iterating
    always_comb begin
        w_div0     = is_div(w_op) && (rs2_val == '0);
        w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (rs1_val == MOST_NEG) && (rs2_val == '1);
        w_fast     = w_div0 || w_ovf;
        w_fast_res = '0;
        if (w_div0)
            w_fast_res = is_rem(w_op) ? rs1_val : '1;
        else if (w_ovf)
            w_fast_res = is_rem(w_op) ? '0 : rs1_val;
    end

    // Apply the result sign to the value the final iteration produces
    always_comb begin
        w_prod_s = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
        w_quo_s  = r_neg ? -w_lo : w_lo;
        w_rem_s  = r_neg ? -w_hi : w_hi;
        case (r_op)
            OP_MUL:                        w_final = w_prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:               w_final = w_quo_s;
            default:                       w_final = w_rem_s;
        endcase
    end

    muldiv_iter_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept && !w_fast),
        .i_step    ((r_state == CALC) && !flush),
        .i_div     (is_div(w_op)),
        .i_a       (w_a_mag),
        .i_b       (w_b_mag),
        .o_last    (w_last),
        .o_next_hi (w_hi),
        .o_next_lo (w_lo)
    );

    // Control FSM; destination and result are held until the next op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op  <= w_op;
                        r_neg <= w_res_neg;
                        r_rd  <= rd_addr;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_result <= w_final;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
